// File: rtl/uart_param_regs.sv
// Serial-programmable parameter register file: parses SYNC/CMD/DATA/CSUM frames from
// the UART receive stream, commits writes, and answers with ACK/NAK plus readback bytes.
module uart_param_regs #(
    parameter int         NUM_REGS       = 8,
    parameter int         REG_BYTES      = 6,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_ready,
    output logic [7:0]                    tx_data,
    output logic                          tx_send,
    input  logic                          tx_ready,
    output logic [NUM_REGS*8*REG_BYTES-1:0] regs,
    output logic [NUM_REGS-1:0]           update,
    output logic                          busy
);
    localparam int         W   = 8 * REG_BYTES;
    localparam int         IW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int         TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int         CW  = $clog2(REG_BYTES + 1);
    localparam int         RW  = $clog2(REG_BYTES + 2);
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_CSUM, S_RESP, S_RESP_WAIT} state_t;

    state_t                       state;
    logic [NUM_REGS-1:0][W-1:0]   reg_q;
    logic [7:0]                   cmd;
    logic [7:0]                   csum;
    logic [W-1:0]                 shadow;
    logic [CW-1:0]                byte_cnt;
    logic [TW-1:0]                tmo;
    logic [W+7:0]                 resp_buf;
    logic [RW-1:0]                resp_left;
    logic                         skip;

    logic [IW-1:0] idx;
    logic          in_range, is_rd, csum_ok;
    logic [7:0]    rsp_code;
    logic [W+7:0]  rsp_new;
    logic [RW-1:0] rsp_len;

    assign idx      = cmd[IW-1:0];
    assign in_range = {1'b0, cmd[6:0]} < 8'(NUM_REGS);
    assign is_rd    = cmd[7];
    assign csum_ok  = (rx_data == csum) && in_range;
    assign rsp_code = csum_ok ? ACK : NAK;
    // Readback is captured into the response buffer at CSUM acceptance.
    assign rsp_new  = {rsp_code, (csum_ok && is_rd) ? reg_q[idx] : {W{1'b0}}};
    assign rsp_len  = (csum_ok && is_rd) ? RW'(REG_BYTES + 1) : RW'(1);

    assign regs = reg_q;
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            reg_q     <= '0;
            cmd       <= '0;
            csum      <= '0;
            shadow    <= '0;
            byte_cnt  <= '0;
            tmo       <= '0;
            resp_buf  <= '0;
            resp_left <= '0;
            skip      <= 1'b0;
            tx_data   <= '0;
            tx_send   <= 1'b0;
            update    <= '0;
        end else begin
            tx_send <= 1'b0;
            update  <= '0;

            // Inter-byte timeout; the frame states below only change state on rx_ready.
            if (state == S_CMD || state == S_DATA || state == S_CSUM) begin
                if (rx_ready)                           tmo <= '0;
                else if (tmo == TW'(TIMEOUT_CYCLES - 1)) state <= S_IDLE;
                else                                    tmo <= tmo + 1'b1;
            end

            case (state)
                S_IDLE: if (rx_ready && rx_data == SYNC_BYTE) begin
                    state <= S_CMD;
                    tmo   <= '0;
                end
                S_CMD: if (rx_ready) begin
                    cmd      <= rx_data;
                    csum     <= rx_data;
                    byte_cnt <= '0;
                    state    <= rx_data[7] ? S_CSUM : S_DATA;
                end
                S_DATA: if (rx_ready) begin
                    shadow   <= W'({shadow, rx_data});
                    csum     <= csum ^ rx_data;
                    byte_cnt <= byte_cnt + 1'b1;
                    if (byte_cnt == CW'(REG_BYTES - 1)) state <= S_CSUM;
                end
                S_CSUM: if (rx_ready) begin
                    if (csum_ok && !is_rd) begin
                        reg_q[idx]  <= shadow;
                        update[idx] <= 1'b1;
                    end
                    // Send the first byte straight away when the transmitter is idle.
                    if (tx_ready) begin
                        tx_data   <= rsp_code;
                        tx_send   <= 1'b1;
                        resp_buf  <= rsp_new << 8;
                        resp_left <= rsp_len - 1'b1;
                        skip      <= 1'b1;
                        state     <= S_RESP_WAIT;
                    end else begin
                        resp_buf  <= rsp_new;
                        resp_left <= rsp_len;
                        state     <= S_RESP;
                    end
                end
                S_RESP: if (tx_ready) begin
                    tx_data   <= resp_buf[W+7 -: 8];
                    tx_send   <= 1'b1;
                    resp_buf  <= resp_buf << 8;
                    resp_left <= resp_left - 1'b1;
                    skip      <= 1'b1;
                    state     <= S_RESP_WAIT;
                end
                S_RESP_WAIT: begin
                    // tx_ready is stale in the cycle tx_send is seen by the transmitter.
                    if (skip) skip <= 1'b0;
                    else if (tx_ready) state <= (resp_left != '0) ? S_RESP : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_param_regs.sv
// Table-driven bench for uart_param_regs: frames from a vector table, response bytes
// checked through a scoreboard queue, plus hand sequences for timeout and async reset.
module tb_uart_param_regs;
    localparam int NR = 8;
    localparam int RB = 6;
    localparam int W  = 8 * RB;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_ready = 1'b0;
    logic [7:0]        tx_data;
    logic              tx_send;
    logic              tx_ready = 1'b1;
    logic [NR*W-1:0]   regs;
    logic [NR-1:0]     update;
    logic              busy;

    uart_param_regs #(.NUM_REGS(NR), .REG_BYTES(RB), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_send(tx_send), .tx_ready(tx_ready),
        .regs(regs), .update(update), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:9][7:0] fr;
        int              len;
        logic [0:6][7:0] rsp;
        int              nrsp;
        bit              wr;
        int              idx;
        logic [W-1:0]    val;
    } vec_t;

    vec_t          v[9];
    logic [7:0]    exp_q[$];
    logic [W-1:0]  mdl[NR];
    int            n_chk = 0;
    int            n_fail = 0;
    int            upd_cnt;
    logic [NR-1:0] upd_mask;
    logic [NR*W-1:0] regs_at_upd;
    logic [7:0]    e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, expv);
        end
    endtask

    // Scoreboard side: every tx_send pops one expected byte.
    always @(negedge clk) begin
        if (tx_send) begin
            chk("tx_ready_at_send", 64'(tx_ready), 64'd1);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_tx: got %0h, required no byte", tx_data);
            end else begin
                e = exp_q.pop_front();
                chk("tx_byte", 64'(tx_data), 64'(e));
            end
        end
        if (update != '0) begin
            upd_cnt++;
            upd_mask |= update;
            regs_at_upd = regs;
        end
    end

    // Transmitter model: busy for a few cycles after each accepted byte.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_send) begin
                @(posedge clk);
                #1 tx_ready = 1'b0;
                repeat ($urandom_range(2, 6)) @(posedge clk);
                #1 tx_ready = 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic drain(input string name);
        int cnt = 0;
        while (!(exp_q.size() == 0 && !busy && tx_ready) && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        chk(name, 64'(cnt < 2000), 64'd1);
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < NR; i++) chk(name, 64'(regs[i*W +: W]), 64'(mdl[i]));
    endtask

    task automatic run_vec(input int k);
        for (int j = 0; j < v[k].nrsp; j++) exp_q.push_back(v[k].rsp[j]);
        upd_cnt  = 0;
        upd_mask = '0;
        for (int j = 0; j < v[k].len; j++) begin
            send_byte(v[k].fr[j]);
            if (j == v[k].len - 1) chk("first_tx_latency", 64'(tx_send), 64'd1);
            else repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain("resp_done");
        if (v[k].wr) mdl[v[k].idx] = v[k].val;
        chk("update_count", 64'(upd_cnt), v[k].wr ? 64'd1 : 64'd0);
        chk("update_mask", 64'(upd_mask), v[k].wr ? 64'(1 << v[k].idx) : 64'd0);
        if (v[k].wr) chk("value_at_update", 64'(regs_at_upd[v[k].idx*W +: W]), 64'(v[k].val));
        check_regs("regs_after_frame");
    endtask

    initial begin
        v[0] = '{fr:80'hA5021122334455667500, len:9, rsp:56'h06000000000000, nrsp:1, wr:1, idx:2, val:48'h112233445566};
        v[1] = '{fr:80'hA5828200000000000000, len:3, rsp:56'h06112233445566, nrsp:7, wr:0, idx:0, val:'0};
        v[2] = '{fr:80'hA502AAAAAAAAAAAA0000, len:9, rsp:56'h15000000000000, nrsp:1, wr:0, idx:0, val:'0};
        v[3] = '{fr:80'h00FFA589890000000000, len:5, rsp:56'h15000000000000, nrsp:1, wr:0, idx:0, val:'0};
        v[4] = '{fr:80'hA50A0102030405060D00, len:9, rsp:56'h15000000000000, nrsp:1, wr:0, idx:0, val:'0};
        v[5] = '{fr:80'hA507DEADBEEF00012400, len:9, rsp:56'h06000000000000, nrsp:1, wr:1, idx:7, val:48'hDEADBEEF0001};
        v[6] = '{fr:80'hA5878700000000000000, len:3, rsp:56'h06DEADBEEF0001, nrsp:7, wr:0, idx:0, val:'0};
        v[7] = '{fr:80'hA5020102030405060500, len:9, rsp:56'h06000000000000, nrsp:1, wr:1, idx:2, val:48'h010203040506};
        v[8] = '{fr:80'hA5828200000000000000, len:3, rsp:56'h06000000000000, nrsp:7, wr:0, idx:0, val:'0};
        for (int i = 0; i < NR; i++) mdl[i] = '0;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {49'(regs != '0), 8'(update), tx_data, tx_send, busy}, 64'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k <= 6; k++) run_vec(k);

        // Abandoned frame: no response, busy falls after the timeout.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        repeat (990) @(negedge clk);
        chk("busy_before_timeout", 64'(busy), 64'd1);
        repeat (20) @(negedge clk);
        chk("busy_after_timeout", 64'(busy), 64'd0);
        check_regs("regs_after_timeout");
        run_vec(7);

        // Asynchronous reset in the middle of a write frame.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        chk("busy_mid_frame", 64'(busy), 64'd1);
        #2 rstn = 1'b0;
        #1 chk("async_reset_outputs", {49'(regs != '0), 8'(update), tx_data, tx_send, busy}, 64'd0);
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        run_vec(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_param_regs.md
Name: uart_param_regs

Overview:
- Serial-programmable parameter register file; replaces the plain UART echo loop between uart_receive and uart_transmit.
- Parses framed read/write commands from the receive byte stream and holds NUM_REGS registers of REG_BYTES bytes each.
- Registers drive runtime settings such as IPInfo fields and payload words for the Ethernet/UDP transmitter.
- Responds with ACK/NAK and readback bytes through the transmitter handshake.

Parameters:
- NUM_REGS, 8: number of registers; index range 0..NUM_REGS-1, max 128.
- REG_BYTES, 6: bytes per register; width W = 8*REG_BYTES, so 48 fits a MAC address.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 1_000_000: idle clk cycles allowed between bytes inside a frame before the frame is abandoned.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous, active-low reset.
- rx_data  input  8  byte from uart_receive; valid when rx_ready=1.
- rx_ready  input  1  one-cycle pulse per received byte.
- tx_data  output  8  byte to uart_transmit.
- tx_send  output  1  one-cycle pulse requesting transmission of tx_data.
- tx_ready  input  1  transmitter idle; drops the cycle after tx_send and stays low until the byte is done.
- regs  output  NUM_REGS*W  flattened registers; reg i occupies [(i+1)*W-1 : i*W].
- update  output  NUM_REGS  one-cycle pulse on bit i when reg i is committed.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rstn=0):
  - All regs = 0; tx_data = 0; tx_send = 0; update = 0; busy = 0; state = IDLE.
  - A reset mid-frame or mid-response discards everything; no partial commit.
- Frame format:
  - Bytes in order: SYNC, CMD, then REG_BYTES data bytes MSB-first (write only), then CSUM.
  - CMD[7] = 1 for read, 0 for write; CMD[6:0] = register index.
  - CSUM = XOR of CMD and all data bytes. For a read, CSUM = CMD.
- States: IDLE, CMD, DATA, CSUM, RESP, RESP_WAIT.
- IDLE:
  - rx byte == SYNC goes to CMD.
  - Any other byte is ignored.
- CMD: latch the command byte, start the running XOR. Write goes to DATA; read goes to CSUM.
- DATA:
  - Shift each byte into a W-bit shadow register and XOR it into the checksum.
  - After REG_BYTES bytes, go to CSUM.
- CSUM, on byte arrival:
  - ok = (byte == running XOR) and (index < NUM_REGS).
  - Write with ok: commit shadow to reg[index] on the next edge; update[index] pulses in the same cycle the new value appears on regs.
  - Response plan: ok write gives ACK 8'h06; ok read gives ACK followed by REG_BYTES bytes of reg[index], MSB-first; not ok gives NAK 8'h15 and no commit.
  - Out-of-range writes still consume all data and CSUM bytes before the NAK.
- RESP:
  - When tx_ready=1, drive tx_data and pulse tx_send for one cycle, then go to RESP_WAIT.
  - tx_send is never asserted while tx_ready=0.
- RESP_WAIT:
  - Ignore tx_ready for the first cycle after tx_send.
  - Then wait for tx_ready=1. If bytes remain, return to RESP; otherwise go to IDLE.
- Read data is snapshotted at CSUM acceptance, so readback is coherent.
- Latency: if tx_ready=1, the first tx_send occurs 1 cycle after the rx_ready of the CSUM byte.
- Timeout:
  - In CMD, DATA and CSUM, a counter reloads on every rx_ready.
  - Reaching TIMEOUT_CYCLES with no byte returns to IDLE silently.
- rx bytes arriving during RESP or RESP_WAIT are dropped; SYNC is not honoured there.
- A SYNC byte inside DATA/CSUM is treated as data, not as a resync.
- rx_ready and a tx_ready change in the same cycle are handled independently.

Test Plan:
- Write: reset, then rx A5 02 11 22 33 44 55 66 75 -> tx 06; reg2 = 48'h112233445566; update = 8'b0000_0100 for exactly 1 cycle; other regs stay 0.
- Read: after the write, rx A5 82 82 -> tx 06 11 22 33 44 55 66. tx_send only with tx_ready=1, one pulse per byte; regs unchanged.
- Bad checksum: rx A5 02 AA AA AA AA AA AA 00 -> tx 15; reg2 unchanged; no update pulse.
- Out of range and garbage: rx 00 FF A5 89 89 -> leading bytes ignored, tx 15. rx A5 0A plus 6 data bytes plus correct CSUM (NUM_REGS=8) -> tx 15; no commit.
- Timeout: rx A5 02 11, then silence for TIMEOUT_CYCLES (set to 1000 in the bench) -> no tx, busy falls. A subsequent valid write frame -> 06 and commit.
- Reset mid-frame: rstn low after A5 02 11 22 -> all outputs 0 immediately (async). After release, a valid read of reg 2 -> 06 00 00 00 00 00 00.
